board_update_ctrl: RTL and testbench

- Owns the 64-square x 4-bit chess board register.
- Sequences its single write port between two sources:
  - an internal initial-position loader, which runs after reset or on a new-game request;
  - the game-logic move/erase write stream.
- Exports the packed 256-bit board to game logic and display, plus status flags and per-colour capture counters.

---
 rtl/board_update_ctrl.sv | 148 ++++++++++++++
 tb/tb_board_update_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_update_ctrl.sv
// Chess board register with an initial-position loader and a game-logic write port.
// Tracks untouched-initial-position status and per-colour capture counts.
module board_update_ctrl #(
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter int unsigned CAP_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic             wr_en,
    input  logic [5:0]       wr_addr,
    input  logic [3:0]       wr_piece,
    output logic [255:0]     board_out,
    output logic             busy,
    output logic             init_done,
    output logic             is_in_initial_state,
    output logic             wr_drop,
    output logic [CAP_W-1:0] white_captured,
    output logic [CAP_W-1:0] black_captured
);

    localparam int unsigned SQ_W  = 6;
    localparam int unsigned BRD_W = 256;
    localparam logic [SQ_W-1:0]  LAST_SQ = SQ_W'(63);
    localparam logic [CAP_W-1:0] CAP_MAX = '1;

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [SQ_W-1:0]    cnt_q, cnt_d;
    logic [BRD_W-1:0]   board_q, board_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               initial_q, initial_d;
    logic               drop_q, drop_d;
    logic [CAP_W-1:0]   wcap_q, wcap_d;
    logic [CAP_W-1:0]   bcap_q, bcap_d;
    logic [3:0]         old_piece_c;

    // Starting position: black on rows 0-1, white on rows 6-7.
    function automatic logic [3:0] init_rom(input logic [SQ_W-1:0] sq);
        logic [2:0] back_type;
        case (sq[2:0])
            3'd0, 3'd7: back_type = 3'd4;
            3'd1, 3'd6: back_type = 3'd3;
            3'd2, 3'd5: back_type = 3'd2;
            3'd3:       back_type = 3'd5;
            default:    back_type = 3'd6;
        endcase
        case (sq[5:3])
            3'd0:    init_rom = {1'b1, back_type};
            3'd1:    init_rom = 4'h9;
            3'd6:    init_rom = 4'h1;
            3'd7:    init_rom = {1'b0, back_type};
            default: init_rom = 4'h0;
        endcase
    endfunction

    assign old_piece_c = board_q[{wr_addr, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_ON_RESET ? S_INIT : S_IDLE;
            cnt_q     <= '0;
            board_q   <= '0;
            busy_q    <= INIT_ON_RESET;
            done_q    <= 1'b0;
            initial_q <= 1'b0;
            drop_q    <= 1'b0;
            wcap_q    <= '0;
            bcap_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            board_q   <= board_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            initial_q <= initial_d;
            drop_q    <= drop_d;
            wcap_q    <= wcap_d;
            bcap_q    <= bcap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        board_d   = board_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        initial_d = initial_q;
        wcap_d    = wcap_q;
        bcap_d    = bcap_q;

        case (state_q)
            S_INIT: begin
                board_d[{cnt_q, 2'b00} +: 4] = init_rom(cnt_q);
                drop_d = wr_en;
                if (new_game) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_SQ) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    initial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + SQ_W'(1);
                end
            end
            default: begin
                if (new_game) begin
                    // Loader overwrites every square, so the board is left as is.
                    state_d   = S_INIT;
                    cnt_d     = '0;
                    drop_d    = wr_en;
                    initial_d = 1'b0;
                    wcap_d    = '0;
                    bcap_d    = '0;
                end else if (wr_en) begin
                    board_d[{wr_addr, 2'b00} +: 4] = wr_piece;
                    initial_d = 1'b0;
                    // A capture: non-empty piece replaced by a non-empty piece of the other colour.
                    if ((old_piece_c[2:0] != 3'd0) && (wr_piece[2:0] != 3'd0) &&
                        (old_piece_c[3] != wr_piece[3])) begin
                        if (old_piece_c[3]) begin
                            if (bcap_q != CAP_MAX) bcap_d = bcap_q + CAP_W'(1);
                        end else begin
                            if (wcap_q != CAP_MAX) wcap_d = wcap_q + CAP_W'(1);
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d == S_INIT);
    end

    assign board_out           = board_q;
    assign busy                = busy_q;
    assign init_done           = done_q;
    assign is_in_initial_state = initial_q;
    assign wr_drop             = drop_q;
    assign white_captured      = wcap_q;
    assign black_captured      = bcap_q;

endmodule

// File: tb/tb_board_update_ctrl.sv
// Scoreboard bench for board_update_ctrl: a reference model queues expected outputs per cycle,
// a monitor compares them on the falling edge; directed scenarios plus random traffic.
module tb_board_update_ctrl;

    localparam int unsigned CAP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             new_game = 1'b0;
    logic             wr_en = 1'b0;
    logic [5:0]       wr_addr = '0;
    logic [3:0]       wr_piece = '0;
    logic [255:0]     board_out;
    logic             busy;
    logic             init_done;
    logic             is_in_initial_state;
    logic             wr_drop;
    logic [CAP_W-1:0] white_captured;
    logic [CAP_W-1:0] black_captured;

    board_update_ctrl #(.INIT_ON_RESET(1'b1), .CAP_W(CAP_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .new_game            (new_game),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_piece            (wr_piece),
        .board_out           (board_out),
        .busy                (busy),
        .init_done           (init_done),
        .is_in_initial_state (is_in_initial_state),
        .wr_drop             (wr_drop),
        .white_captured      (white_captured),
        .black_captured      (black_captured)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] board;
        logic         busy;
        logic         done;
        logic         init;
        logic         drop;
        int           wc;
        int           bc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_board[64];
    bit         m_loading;
    int         m_cnt;
    bit         m_init;
    int         m_wc, m_bc;

    function automatic logic [3:0] init_piece(int sq);
        int back[8] = '{4, 3, 2, 5, 6, 2, 3, 4};
        int row = sq / 8;
        int col = sq % 8;
        if (row == 0) return 4'(8 + back[col]);
        if (row == 1) return 4'h9;
        if (row == 6) return 4'h1;
        if (row == 7) return 4'(back[col]);
        return 4'h0;
    endfunction

    task automatic check_val(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("board", board_out, e.board);
            check_val("busy", 256'(busy), 256'(e.busy));
            check_val("init_done", 256'(init_done), 256'(e.done));
            check_val("is_initial", 256'(is_in_initial_state), 256'(e.init));
            check_val("wr_drop", 256'(wr_drop), 256'(e.drop));
            check_val("white_cap", 256'(white_captured), 256'(e.wc));
            check_val("black_cap", 256'(black_captured), 256'(e.bc));
        end
    end

    // Apply one cycle of inputs, advance the model, queue what the DUT must show afterwards.
    task automatic step(bit r, bit ng, bit we, logic [5:0] a, logic [3:0] p);
        exp_t e;
        logic [3:0] old;
        rst = r; new_game = ng; wr_en = we; wr_addr = a; wr_piece = p;
        e.done = 1'b0;
        e.drop = 1'b0;
        if (r) begin
            foreach (m_board[i]) m_board[i] = 4'h0;
            m_loading = 1'b1; m_cnt = 0; m_init = 1'b0; m_wc = 0; m_bc = 0;
        end else if (m_loading) begin
            m_board[m_cnt] = init_piece(m_cnt);
            e.drop = we;
            if (ng) m_cnt = 0;
            else if (m_cnt == 63) begin
                m_loading = 1'b0; e.done = 1'b1; m_init = 1'b1;
            end else m_cnt++;
        end else if (ng) begin
            m_loading = 1'b1; m_cnt = 0; m_wc = 0; m_bc = 0; m_init = 1'b0;
            e.drop = we;
        end else if (we) begin
            old = m_board[a];
            if (old[2:0] != 0 && p[2:0] != 0 && old[3] != p[3]) begin
                if (old[3]) m_bc = (m_bc < 15) ? m_bc + 1 : 15;
                else        m_wc = (m_wc < 15) ? m_wc + 1 : 15;
            end
            m_board[a] = p;
            m_init = 1'b0;
        end
        for (int i = 0; i < 64; i++) e.board[4*i +: 4] = m_board[i];
        e.busy = m_loading;
        e.init = m_init;
        e.wc = m_wc;
        e.bc = m_bc;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 6'd0, 4'h0);
    endtask

    // Run until init_done, bounded; expect it on the 64th cycle after the loader starts.
    task automatic wait_done(string name);
        int n = 0;
        bit seen = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            idle();
            if (init_done === 1'b1) begin seen = 1; n = i; end
        end
        check_val(name, 256'(n), 256'(64));
    endtask

    function automatic logic [3:0] sq(int n);
        return board_out[4*n +: 4];
    endfunction

    initial begin
        @(negedge clk);
        #1;

        // Reset and initial load
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'h0);
        check_val("reset_busy", 256'(busy), 256'(1));
        check_val("reset_board", board_out, 256'(0));
        wait_done("load_latency");
        check_val("sq0", 256'(sq(0)), 256'(4'hC));
        check_val("sq4", 256'(sq(4)), 256'(4'hE));
        check_val("sq56", 256'(sq(56)), 256'(4'h4));
        check_val("sq52", 256'(sq(52)), 256'(4'h1));
        check_val("sq27", 256'(sq(27)), 256'(4'h0));
        check_val("initial_after_load", 256'(is_in_initial_state), 256'(1));
        idle();
        check_val("done_one_cycle", 256'(init_done), 256'(0));

        // Simple move
        step(1'b0, 1'b0, 1'b1, 6'd36, 4'h1);
        check_val("move_sq36", 256'(sq(36)), 256'(4'h1));
        check_val("move_initial", 256'(is_in_initial_state), 256'(0));
        step(1'b0, 1'b0, 1'b1, 6'd52, 4'h0);
        check_val("move_sq52", 256'(sq(52)), 256'(4'h0));
        check_val("move_caps", 256'({white_captured, black_captured}), 256'(0));

        // Capture and saturation
        step(1'b0, 1'b0, 1'b1, 6'd8, 4'h5);
        check_val("cap_black1", 256'(black_captured), 256'(1));
        check_val("cap_white0", 256'(white_captured), 256'(0));
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 6'd9, 4'hD);
            step(1'b0, 1'b0, 1'b1, 6'd9, 4'h5);
        end
        check_val("cap_saturate", 256'(black_captured), 256'(15));

        // Write during load
        step(1'b0, 1'b1, 1'b0, 6'd0, 4'h0);
        for (int i = 1; i <= 64; i++) begin
            step(1'b0, 1'b0, i == 10, 6'd20, 4'h5);
            if (i == 10) begin
                check_val("load_wr_drop", 256'(wr_drop), 256'(1));
                check_val("load_busy", 256'(busy), 256'(1));
            end
            if (i == 11) check_val("load_drop_pulse", 256'(wr_drop), 256'(0));
        end
        check_val("load_done", 256'(init_done), 256'(1));
        check_val("load_sq20", 256'(sq(20)), 256'(4'h0));
        check_val("load_caps", 256'({white_captured, black_captured}), 256'(0));
        check_val("load_initial", 256'(is_in_initial_state), 256'(1));

        // Collision of new_game and a write
        step(1'b0, 1'b1, 1'b1, 6'd0, 4'h6);
        check_val("coll_drop", 256'(wr_drop), 256'(1));
        check_val("coll_busy", 256'(busy), 256'(1));
        repeat (64) idle();
        check_val("coll_sq0", 256'(sq(0)), 256'(4'hC));

        // Reset mid-load
        step(1'b0, 1'b1, 1'b0, 6'd0, 4'h0);
        repeat (30) idle();
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'h0);
        check_val("midrst_board", board_out, 256'(0));
        check_val("midrst_busy", 256'(busy), 256'(1));
        wait_done("midrst_latency");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] p;
            p = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 6))};
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) != 0, 6'($urandom_range(0, 63)), p);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
